// File: rtl/systolic_pkg.sv
// systolic_pkg: shared drain-controller types, default array sizing and column slice helper.
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, OUT} drain_state_t;
  localparam int DEF_N = 4;
  localparam int DEF_DW = 8;
  // Low bit of column j inside a packed row of dw-bit columns.
  function automatic int col_lsb(input int j, input int dw);
    return j * dw;
  endfunction
endpackage

// File: rtl/drain_row_buffer.sv
// drain_row_buffer: N-entry row register file, synchronous write, combinational read.
// Ports: clk, rst (async active-low clear), wr_en/wr_idx/wr_data write port,
//        rd_idx/rd_data combinational read port.
module drain_row_buffer #(
  parameter int N = 4,
  parameter int DW = 8,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [N*DW-1:0] wr_data,
  input  logic [IW-1:0]   rd_idx,
  output logic [N*DW-1:0] rd_data
);
  logic [N*DW-1:0] mem [N];
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < N; i++) mem[i] <= '0;
    else if (wr_en)
      mem[wr_idx] <= wr_data;
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/systolic_drain_ctrl.sv
// systolic_drain_ctrl: drains the PE array c-chains into a row buffer and streams rows out top-first.
// Ports: clk, rst (async active-low), start pulse, col_c_in (bottom-row c_out per column),
//        mode (PE shift enable), busy, out_valid/out_ready/out_row/out_row_idx handshake,
//        done (pulse on acceptance of the last row).
module systolic_drain_ctrl
  import systolic_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int DW = DEF_DW,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N*DW-1:0] col_c_in,
  output logic            mode,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_row,
  output logic [IW-1:0]   out_row_idx,
  output logic            done
);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  drain_state_t state, state_n;
  logic [IW-1:0] cnt, cnt_n, r, r_n, wr_idx;
  logic mode_n, done_n, wr_en;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      r     <= '0;
      mode  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      r     <= r_n;
      mode  <= mode_n;
      done  <= done_n;
    end
  // Shift cycle k sees row N-1-k at the bottom of the chain, so rows land bottom-up.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    r_n     = r;
    mode_n  = mode;
    done_n  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = LAST - cnt;
    case (state)
      IDLE:
        if (start) begin
          state_n = SHIFT;
          cnt_n   = '0;
          mode_n  = 1'b1;
        end
      SHIFT: begin
        wr_en = 1'b1;
        if (cnt == LAST) begin
          state_n = OUT;
          mode_n  = 1'b0;
          r_n     = '0;
        end else
          cnt_n = cnt + 1'b1;
      end
      OUT:
        if (out_ready) begin
          if (r == LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
            r_n     = '0;
          end else
            r_n = r + 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  assign busy        = state != IDLE;
  assign out_valid   = state == OUT;
  assign out_row_idx = r;
  drain_row_buffer #(.N(N), .DW(DW), .IW(IW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (col_c_in),
    .rd_idx  (r),
    .rd_data (out_row)
  );
endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// tb_systolic_drain_ctrl: scoreboard bench with a PE c-chain model feeding the drain controller.
module tb_systolic_drain_ctrl;
  import systolic_pkg::*;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [N*DW-1:0] col_c_in, out_row;
  logic [IW-1:0] out_row_idx;
  logic mode, busy, out_valid, done;
  logic [DW-1:0] c [N][N];
  logic [N*DW-1:0] q_row [$];
  logic [IW-1:0] q_idx [$];
  int n_cmp = 0;
  int n_bad = 0;
  int mode_cycles = 0;
  bit exp_done = 1'b0;

  systolic_drain_ctrl #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .col_c_in    (col_c_in),
    .mode        (mode),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] acc(input int r, input int j);
    return DW'(16 * r + j);
  endfunction

  function automatic logic [N*DW-1:0] exp_row(input int r);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[col_lsb(j, DW) +: DW] = acc(r, j);
    return v;
  endfunction

  // PE array model: mode=1 shifts each column down (top fed 0), mode=0 reloads the accumulator.
  always @(posedge clk)
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        c[r][j] <= mode ? ((r == 0) ? '0 : c[r-1][j]) : acc(r, j);

  always @* begin
    col_c_in = '0;
    for (int j = 0; j < N; j++) col_c_in[col_lsb(j, DW) +: DW] = c[N-1][j];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks the done pulse.
  always @(negedge clk)
    if (!rst)
      exp_done = 1'b0;
    else begin
      if (out_valid && out_ready) begin
        if (q_row.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_row: got idx %0d row %0h with empty scoreboard", out_row_idx, out_row);
        end else begin
          chk("row", out_row, q_row.pop_front());
          chk("row_idx", out_row_idx, q_idx.pop_front());
        end
      end
      if (done || exp_done) chk("done", done, exp_done);
      exp_done = out_valid && out_ready && out_row_idx == IW'(N - 1);
      if (mode) mode_cycles++;
    end

  task automatic push_all();
    for (int r = 0; r < N; r++) begin
      q_row.push_back(exp_row(r));
      q_idx.push_back(IW'(r));
    end
  endtask

  task automatic pulse_start(input bit accept);
    start = 1'b1;
    if (accept) push_all();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    // 1. reset state, then idle with start low
    #2;
    chk("rst_mode", mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_row", out_row, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_mode", mode, 0);
    end
    chk("idle_valid", out_valid, 0);
    chk("idle_row", out_row, 0);
    @(posedge clk);
    #1;
    // 2. full drain with consumer always ready
    out_ready = 1'b1;
    pulse_start(1);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("mode_high", mode, 1);
    end
    @(negedge clk);
    chk("mode_low", mode, 0);
    wait_done();
    chk("q_empty_t2", q_row.size(), 0);
    @(posedge clk);
    #1;
    // 3. back-pressure while idx 2 is presented
    pulse_start(1);
    repeat (6) @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_row", out_row, 32'h23222120);
      chk("hold_idx", out_row_idx, 2);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done();
    chk("q_empty_t3", q_row.size(), 0);
    @(posedge clk);
    #1;
    // 4. start ignored in SHIFT/OUT, accepted in the done cycle
    mode_cycles = 0;
    pulse_start(1);
    pulse_start(0);
    repeat (4) @(posedge clk);
    #1;
    chk("out_state", out_valid, 1);
    pulse_start(0);
    wait_done();
    start = 1'b1;
    push_all();
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("mode_total", mode_cycles, 2 * N);
    chk("q_empty_t4", q_row.size(), 0);
    @(posedge clk);
    #1;
    // 5. asynchronous reset at SHIFT cnt=2, then a fresh drain
    pulse_start(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_mode", mode, 1);
    rst = 1'b0;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    q_row.delete();
    q_idx.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    pulse_start(1);
    wait_done();
    @(negedge clk);
    chk("q_empty_t5", q_row.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
